// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider.
// Takes one iteration per clock and signals completion with a one-cycle done pulse.
module iter_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic [1:0]       flags
);
    localparam int CNTW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b100;
    localparam logic [2:0] OP_SDIV  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [1:0]       flags_q, flags_d;

    logic               in_signed;
    logic               in_legal;
    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic               signs_differ;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // acc_q holds the product upper half or the partial remainder; lo_q the multiplier or quotient.
    always_comb begin
        in_signed    = (op == OP_SMULL) || (op == OP_SDIV);
        in_legal     = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) ||
                       (op == OP_UDIV) || (op == OP_SDIV);
        accept       = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
        a_mag        = (in_signed && a[WIDTH-1]) ? -a : a;
        b_mag        = (in_signed && b[WIDTH-1]) ? -b : b;
        mul_sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_sh       = {acc_q, lo_q[WIDTH-1]};
        div_ge       = div_sh >= {1'b0, mcand_q};
        signs_differ = sign_a_q ^ sign_b_q;
        prod         = {acc_q, lo_q};
        prod_fix     = ((op_q == OP_SMULL) && signs_differ) ? -prod : prod;
        quo_fix      = ((op_q == OP_SDIV) && signs_differ) ? -lo_q : lo_q;
        rem_fix      = ((op_q == OP_SDIV) && sign_a_q) ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        a_orig_d   = a_orig_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        flags_d    = flags_q;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (op_q[2]) begin
                    acc_d = div_ge ? (div_sh[WIDTH-1:0] - mcand_q) : div_sh[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                div_zero_d = 1'b0;
                case (op_q)
                    OP_MUL: begin
                        res_lo_d = prod_fix[WIDTH-1:0];
                        res_hi_d = '0;
                        flags_d  = {prod_fix[2*WIDTH-1], prod_fix == '0};
                    end
                    OP_UMULL, OP_SMULL: begin
                        res_lo_d = prod_fix[WIDTH-1:0];
                        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        flags_d  = {prod_fix[2*WIDTH-1], prod_fix == '0};
                    end
                    OP_UDIV, OP_SDIV: begin
                        // A zero divisor magnitude only arises from b == 0.
                        if (mcand_q == '0) begin
                            res_lo_d   = '0;
                            res_hi_d   = a_orig_q;
                            div_zero_d = 1'b1;
                            flags_d    = 2'b01;
                        end else begin
                            res_lo_d = quo_fix;
                            res_hi_d = rem_fix;
                            flags_d  = {quo_fix[WIDTH-1], quo_fix == '0};
                        end
                    end
                    default: begin
                        res_lo_d = '0;
                        res_hi_d = '0;
                        flags_d  = 2'b00;
                    end
                endcase
            end
            S_DONE: state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            op_d     = op;
            a_orig_d = a;
            sign_a_d = in_signed && a[WIDTH-1];
            sign_b_d = in_signed && b[WIDTH-1];
            acc_d    = '0;
            cnt_d    = '0;
            lo_d     = op[2] ? a_mag : b_mag;
            mcand_d  = op[2] ? b_mag : a_mag;
            state_d  = in_legal ? S_RUN : S_FIN;
        end

        // Flush discards everything the FIN cycle would have written.
        if (flush) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            div_zero_d = div_zero_q;
            res_lo_d   = res_lo_q;
            res_hi_d   = res_hi_q;
            flags_d    = flags_q;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            a_orig_q   <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            mcand_q    <= mcand_d;
            a_orig_q   <= a_orig_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            flags_q    <= flags_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign div_zero  = div_zero_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_iter_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_zero;
    logic [1:0]   flags;

    int checks   = 0;
    int failures = 0;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .div_zero  (div_zero),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void refModel(input logic [2:0] m_op, input logic [W-1:0] m_a,
                                     input logic [W-1:0] m_b, output logic [W-1:0] m_lo,
                                     output logic [W-1:0] m_hi, output logic m_dz,
                                     output logic [1:0] m_fl);
        logic [63:0] up;
        longint      sp;
        longint      sq;
        longint      sr;
        m_lo = '0;
        m_hi = '0;
        m_dz = 1'b0;
        m_fl = 2'b00;
        case (m_op)
            3'b000, 3'b001: begin
                up   = 64'(m_a) * 64'(m_b);
                m_lo = up[W-1:0];
                m_hi = (m_op == 3'b001) ? up[2*W-1:W] : '0;
                m_fl = {up[2*W-1], up == 64'd0};
            end
            3'b010: begin
                sp   = longint'($signed(m_a)) * longint'($signed(m_b));
                up   = 64'(sp);
                m_lo = up[W-1:0];
                m_hi = up[2*W-1:W];
                m_fl = {sp < 0, sp == 0};
            end
            3'b100, 3'b101: begin
                if (m_b == '0) begin
                    m_hi = m_a;
                    m_dz = 1'b1;
                    m_fl = 2'b01;
                end else begin
                    if (m_op == 3'b100) begin
                        m_lo = m_a / m_b;
                        m_hi = m_a % m_b;
                    end else begin
                        sq   = longint'($signed(m_a)) / longint'($signed(m_b));
                        sr   = longint'($signed(m_a)) % longint'($signed(m_b));
                        m_lo = sq[W-1:0];
                        m_hi = sr[W-1:0];
                    end
                    m_fl = {m_lo[W-1], m_lo == '0};
                end
            end
            default: ;
        endcase
    endfunction

    // Called #1 after an edge while the unit is idle or in its done cycle; returns in the done cycle.
    task automatic applyStimulus(input logic [2:0] s_op, input logic [W-1:0] s_a,
                                 input logic [W-1:0] s_b, input bit hold_start, input string tag);
        logic [W-1:0] e_lo;
        logic [W-1:0] e_hi;
        logic         e_dz;
        logic [1:0]   e_fl;
        int           exp_lat;
        int           cycles;
        refModel(s_op, s_a, s_b, e_lo, e_hi, e_dz, e_fl);
        exp_lat = (s_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ? W + 1 : 1;
        op    = s_op;
        a     = s_a;
        b     = s_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold_start;
        if (hold_start) begin
            op = 3'b001;
            a  = ~s_a;
            b  = s_b + 32'd5;
        end
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
        checkOutput({tag, "_lo"}, 64'(result_lo), 64'(e_lo));
        checkOutput({tag, "_hi"}, 64'(result_hi), 64'(e_hi));
        checkOutput({tag, "_divzero"}, 64'(div_zero), 64'(e_dz));
        checkOutput({tag, "_flags"}, 64'(flags), 64'(e_fl));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic idleCycle(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_lo"}, 64'(result_lo), 64'd0);
        checkOutput({tag, "_hi"}, 64'(result_hi), 64'd0);
        checkOutput({tag, "_divzero"}, 64'(div_zero), 64'd0);
        checkOutput({tag, "_flags"}, 64'(flags), 64'd0);
    endtask

    task automatic watchNoDone(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checkOutput({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0] ops [5];
        logic [2:0] r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        #12;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "umull_max");
        idleCycle("umull_max");
        applyStimulus(3'b010, 32'hFFFFFFFE, 32'd3, 1'b0, "smull_neg");
        idleCycle("smull_neg");
        applyStimulus(3'b100, 32'd100, 32'd7, 1'b0, "udiv");
        applyStimulus(3'b101, 32'hFFFFFFF9, 32'd2, 1'b0, "sdiv_b2b");
        idleCycle("sdiv_b2b");
        applyStimulus(3'b100, 32'h1234, 32'd0, 1'b0, "udiv_zero");
        idleCycle("udiv_zero");
        applyStimulus(3'b000, 32'd5, 32'd6, 1'b0, "mul_small");
        idleCycle("mul_small");
        applyStimulus(3'b101, 32'h80000000, 32'hFFFFFFFF, 1'b0, "sdiv_ovf");
        idleCycle("sdiv_ovf");

        // Flush part-way through a multiply: results of the overflow divide must survive.
        op    = 3'b000;
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_done", 64'(done), 64'd0);
        checkOutput("flush_lo", 64'(result_lo), 64'h80000000);
        checkOutput("flush_hi", 64'(result_hi), 64'd0);
        checkOutput("flush_flags", 64'(flags), 64'(2'b10));
        watchNoDone("flush", 40);

        applyStimulus(3'b100, 32'd1000, 32'd3, 1'b1, "start_held");
        idleCycle("start_held");

        op    = 3'b001;
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("mid_reset");
        #2;
        reset = 1'b1;
        watchNoDone("mid_reset", 40);

        applyStimulus(3'b100, 32'h55, 32'd0, 1'b0, "pre_illegal");
        idleCycle("pre_illegal");
        applyStimulus(3'b111, 32'hDEADBEEF, 32'h1234, 1'b0, "illegal");
        idleCycle("illegal");

        for (int i = 0; i < 30; i++) begin
            r_op = ops[$urandom_range(0, 4)];
            if (i % 10 == 5) r_op = 3'b110;
            r_a = $urandom;
            r_b = (i % 7 == 3) ? 32'd0 : $urandom;
            if (i % 5 == 1) r_b = $urandom_range(1, 15);
            if (i % 9 == 4) r_b = 32'hFFFFFFFF;
            applyStimulus(r_op, r_a, r_b, 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) idleCycle($sformatf("rand%0d", i));
        end
        idleCycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
